// File: rtl/pll_mult_pkg.sv
// rtl/pll_mult_pkg.sv - shared widths, product-width helper and tag type for the PLL multiplier
package pll_mult_pkg;

  // DSP48E1-sized operand widths and the full-precision product they produce
  localparam int DEF_WIDTH_A = 24;
  localparam int DEF_WIDTH_B = 18;
  localparam int DEF_WIDTH_P = 42;

  // Largest requester count the arbiter is sized for
  localparam int MAX_REQ = 8;

  // One-hot requester tag, wide enough for the largest configuration
  typedef logic [MAX_REQ-1:0] req_tag_t;

  // A signed a x b multiply needs a+b bits to hold every product, including (-2^(a-1))*(-2^(b-1))
  function automatic int prod_width(input int width_a, input int width_b);
    return width_a + width_b;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin arbiter with a registered priority pointer
module rr_arbiter
  import pll_mult_pkg::*;
#(
  parameter int N_REQ = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             enable_i,
  input  logic [N_REQ-1:0] req_i,
  output logic [N_REQ-1:0] gnt_o
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef logic [PTR_W-1:0] ptr_t;

  ptr_t             ptr_q;
  ptr_t             ptr_next;
  logic [N_REQ-1:0] gnt;
  logic             found;

  // Pick the first request at or after the pointer, then wrap to the ones below it
  always_comb begin
    gnt      = '0;
    found    = 1'b0;
    ptr_next = ptr_q;
    for (int k = 0; k < N_REQ; k++) begin
      if (!found && req_i[k] && (k >= int'(ptr_q))) begin
        gnt[k]   = 1'b1;
        found    = 1'b1;
        ptr_next = (k == N_REQ - 1) ? '0 : ptr_t'(k + 1);
      end
    end
    for (int k = 0; k < N_REQ; k++) begin
      if (!found && req_i[k] && (k < int'(ptr_q))) begin
        gnt[k]   = 1'b1;
        found    = 1'b1;
        ptr_next = (k == N_REQ - 1) ? '0 : ptr_t'(k + 1);
      end
    end
    // No grants while disabled or held in reset, and the pointer then holds
    if (!enable_i || !rst_ni) begin
      gnt      = '0;
      ptr_next = ptr_q;
    end
  end

  assign gnt_o = gnt;

  // Move the pointer just past each winner so it drops to lowest priority
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_next;
    end
  end

endmodule

// File: rtl/signed_mult_reg.sv
// rtl/signed_mult_reg.sv - registered full-precision signed multiplier, one-cycle latency
module signed_mult_reg #(
  parameter int WIDTH_A = 24,
  parameter int WIDTH_B = 18
) (
  input  logic                              clk_i,
  input  logic                              rst_ni,
  input  logic signed [WIDTH_A-1:0]         a_i,
  input  logic signed [WIDTH_B-1:0]         b_i,
  output logic signed [WIDTH_A+WIDTH_B-1:0] p_o
);

  logic signed [WIDTH_A+WIDTH_B-1:0] a_ext;
  logic signed [WIDTH_A+WIDTH_B-1:0] b_ext;

  // Sign-extend both operands to the product width so the multiply is exact
  assign a_ext = $signed({{WIDTH_B{a_i[WIDTH_A-1]}}, a_i});
  assign b_ext = $signed({{WIDTH_A{b_i[WIDTH_B-1]}}, b_i});

  // Register the product; no rounding or saturation
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      p_o <= '0;
    end else begin
      p_o <= a_ext * b_ext;
    end
  end

endmodule

// File: rtl/shared_multiplier_arbiter.sv
// rtl/shared_multiplier_arbiter.sv - one registered signed multiplier shared round-robin between requesters
module shared_multiplier_arbiter
  import pll_mult_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int WIDTH_A = DEF_WIDTH_A,
  parameter int WIDTH_B = DEF_WIDTH_B
) (
  input  logic                               clk_i,
  input  logic                               rst_ni,
  input  logic                               enable_i,
  input  logic [N_REQ-1:0]                   req_valid_i,
  output logic [N_REQ-1:0]                   req_ready_o,
  input  logic [N_REQ*WIDTH_A-1:0]           a_i,
  input  logic [N_REQ*WIDTH_B-1:0]           b_i,
  output logic [N_REQ*(WIDTH_A+WIDTH_B)-1:0] res_o,
  output logic [N_REQ-1:0]                   res_valid_o,
  output logic                               busy_o
);

  localparam int WIDTH_P = prod_width(WIDTH_A, WIDTH_B);

  logic [N_REQ-1:0]          gnt;
  logic signed [WIDTH_A-1:0] sel_a;
  logic signed [WIDTH_B-1:0] sel_b;

  // Stage 1: captured operands, tag and valid
  logic signed [WIDTH_A-1:0] a_q;
  logic signed [WIDTH_B-1:0] b_q;
  logic [N_REQ-1:0]          tag1_q;
  logic                      v1_q;

  // Stage 2: product sits in the multiplier register, tag and valid ride alongside
  logic signed [WIDTH_P-1:0] prod;
  logic [N_REQ-1:0]          tag2_q;
  logic                      v2_q;

  rr_arbiter #(
    .N_REQ (N_REQ)
  ) u_arb (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .enable_i (enable_i),
    .req_i    (req_valid_i),
    .gnt_o    (gnt)
  );

  // A grant is only ever issued to a valid requester, so ready doubles as the transfer strobe
  assign req_ready_o = gnt;

  // Steer the granted requester's operands towards stage 1; the grant is one-hot or zero
  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (gnt[k]) begin
        sel_a = a_i[k*WIDTH_A +: WIDTH_A];
        sel_b = b_i[k*WIDTH_B +: WIDTH_B];
      end
    end
  end

  // Stage 1 captures the transfer; stage 2 delays tag and valid to match the multiplier
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      a_q    <= '0;
      b_q    <= '0;
      tag1_q <= '0;
      v1_q   <= 1'b0;
      tag2_q <= '0;
      v2_q   <= 1'b0;
    end else begin
      a_q    <= sel_a;
      b_q    <= sel_b;
      tag1_q <= gnt;
      v1_q   <= |gnt;
      tag2_q <= tag1_q;
      v2_q   <= v1_q;
    end
  end

  signed_mult_reg #(
    .WIDTH_A (WIDTH_A),
    .WIDTH_B (WIDTH_B)
  ) u_mult (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .a_i    (a_q),
    .b_i    (b_q),
    .p_o    (prod)
  );

  // Stage 3 writes the product into the tagged requester's hold register and pulses its valid
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      res_o       <= '0;
      res_valid_o <= '0;
    end else begin
      res_valid_o <= v2_q ? tag2_q : '0;
      for (int k = 0; k < N_REQ; k++) begin
        if (v2_q && tag2_q[k]) begin
          res_o[k*WIDTH_P +: WIDTH_P] <= prod;
        end
      end
    end
  end

  // Busy mirrors the stage 1/2/3 valid bits as they will stand after this edge
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      busy_o <= 1'b0;
    end else begin
      busy_o <= (|gnt) | v1_q | v2_q;
    end
  end

endmodule

// File: tb/tb_shared_multiplier_arbiter.sv
// tb/tb_shared_multiplier_arbiter.sv - table-driven, directed and randomized checks of shared_multiplier_arbiter
module tb_shared_multiplier_arbiter;

  localparam int N  = 4;
  localparam int WA = 24;
  localparam int WB = 18;
  localparam int WP = 42;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            enable;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [N*WA-1:0] a_bus;
  logic [N*WB-1:0] b_bus;
  logic [N*WP-1:0] res;
  logic [N-1:0]    res_valid;
  logic            busy;

  always #5 clk = ~clk;

  shared_multiplier_arbiter #(
    .N_REQ   (N),
    .WIDTH_A (WA),
    .WIDTH_B (WB)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .enable_i    (enable),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .a_i         (a_bus),
    .b_i         (b_bus),
    .res_o       (res),
    .res_valid_o (res_valid),
    .busy_o      (busy)
  );

  int checks   = 0;
  int failures = 0;

  // Requester side: valid bits and held operands
  logic [N-1:0] vld;
  logic         en;
  int           a_op [N];
  int           b_op [N];

  // Reference model: pointer, held results, operations in flight with their due cycle
  typedef struct {
    int     k;
    longint p;
    int     due;
  } flight_t;
  flight_t flight[$];
  longint  res_m [N];
  int      ptr_m;
  int      cyc;

  // Values sampled in the most recent cycle
  int           last_g;
  logic [N-1:0] s_ready;
  logic [N-1:0] s_rv;
  logic         s_busy;
  longint       s_res [N];

  typedef struct {
    int     k;
    int     a;
    int     b;
    longint p;
  } vec_t;
  vec_t vecs [7];

  int pulses [N];
  int waited;

  task automatic chk(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int rand_a();
    logic [WA-1:0] r;
    case ($urandom_range(0, 7))
      0:       return -8388608;
      1:       return 8388607;
      default: begin
        r = WA'($urandom);
        return int'($signed(r));
      end
    endcase
  endfunction

  function automatic int rand_b();
    logic [WB-1:0] r;
    case ($urandom_range(0, 7))
      0:       return -131072;
      1:       return 131071;
      default: begin
        r = WB'($urandom);
        return int'($signed(r));
      end
    endcase
  endfunction

  task automatic drive();
    req_valid = vld;
    enable    = en;
    for (int k = 0; k < N; k++) begin
      a_bus[k*WA +: WA] = a_op[k][WA-1:0];
      b_bus[k*WB +: WB] = b_op[k][WB-1:0];
    end
  endtask

  // One clock cycle: predict, sample at the falling edge, compare, advance the model
  task automatic tick();
    int           g;
    logic [N-1:0] exp_ready;
    logic [N-1:0] exp_rv;
    logic         exp_busy;
    drive();
    g = -1;
    if (en) begin
      for (int i = 0; i < N; i++) begin
        int idx;
        idx = (ptr_m + i) % N;
        if (g < 0 && vld[idx]) g = idx;
      end
    end
    exp_ready = '0;
    if (g >= 0) exp_ready[g] = 1'b1;
    exp_rv   = '0;
    exp_busy = 1'b0;
    foreach (flight[j]) begin
      if (flight[j].due == cyc) begin
        exp_rv[flight[j].k] = 1'b1;
        res_m[flight[j].k]  = flight[j].p;
      end
      if (flight[j].due >= cyc && flight[j].due <= cyc + 2) exp_busy = 1'b1;
    end
    @(negedge clk);
    s_ready = req_ready;
    s_rv    = res_valid;
    s_busy  = busy;
    chk($sformatf("ready@%0d", cyc), s_ready, exp_ready);
    chk($sformatf("res_valid@%0d", cyc), s_rv, exp_rv);
    chk($sformatf("busy@%0d", cyc), s_busy, exp_busy);
    for (int k = 0; k < N; k++) begin
      s_res[k] = $signed(res[k*WP +: WP]);
      chk($sformatf("res%0d@%0d", k, cyc), $signed(res[k*WP +: WP]), res_m[k]);
    end
    if (g >= 0) begin
      flight.push_back('{g, longint'(a_op[g]) * longint'(b_op[g]), cyc + 3});
      ptr_m = (g + 1) % N;
    end
    for (int j = flight.size() - 1; j >= 0; j--) begin
      if (flight[j].due <= cyc) flight.delete(j);
    end
    last_g = g;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Hold reset for some cycles checking every output is zero, then release between edges
  task automatic do_reset(input int cycles);
    rst_n = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      drive();
      @(negedge clk);
      chk("rst_ready", req_ready, 0);
      chk("rst_res_valid", res_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_res_nonzero", (res != '0), 0);
      @(posedge clk);
      #1;
    end
    rst_n = 1'b1;
    flight.delete();
    for (int k = 0; k < N; k++) res_m[k] = 0;
    ptr_m = 0;
    cyc   = 0;
  endtask

  initial begin
    vecs[0] = '{2, 1000, -3, -64'sd3000};
    vecs[1] = '{0, -8388608, -131072, 64'sd1099511627776};
    vecs[2] = '{1, 8388607, -131072, -64'sd1099511496704};
    vecs[3] = '{3, 8388607, 131071, 64'sd1099503108097};
    vecs[4] = '{2, -8388608, 131071, -64'sd1099503239168};
    vecs[5] = '{1, -1, -1, 64'sd1};
    vecs[6] = '{3, 0, -77777, 64'sd0};

    rst_n = 1'b0;
    en    = 1'b1;
    vld   = '1;
    for (int k = 0; k < N; k++) begin
      a_op[k] = 0;
      b_op[k] = 0;
    end
    drive();

    // Reset with every requester valid: ready must stay low
    do_reset(3);
    vld = '0;
    tick();
    chk("busy_after_release", s_busy, 0);

    // Table of single transfers, each checked for exact pulse timing and value
    foreach (vecs[i]) begin
      vld              = '0;
      vld[vecs[i].k]   = 1'b1;
      a_op[vecs[i].k]  = vecs[i].a;
      b_op[vecs[i].k]  = vecs[i].b;
      last_g           = -1;
      waited           = 0;
      while (last_g != vecs[i].k && waited < 10) begin
        tick();
        waited++;
      end
      chk($sformatf("vec%0d_grant", i), last_g, vecs[i].k);
      vld[vecs[i].k] = 1'b0;
      tick();
      chk($sformatf("vec%0d_no_early_pulse", i), s_rv, 0);
      tick();
      chk($sformatf("vec%0d_no_early_pulse2", i), s_rv, 0);
      tick();
      chk($sformatf("vec%0d_pulse", i), s_rv, 1 << vecs[i].k);
      chk($sformatf("vec%0d_product", i), s_res[vecs[i].k], vecs[i].p);
      tick();
      chk($sformatf("vec%0d_pulse_end", i), s_rv, 0);
    end

    // Round robin from reset with all requesters continuously valid
    do_reset(2);
    for (int k = 0; k < N; k++) begin
      pulses[k] = 0;
      a_op[k]   = rand_a();
      b_op[k]   = rand_b();
    end
    vld = '1;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk($sformatf("rr_grant%0d", i), last_g, i % N);
      for (int k = 0; k < N; k++) pulses[k] += int'(s_rv[k]);
      if (last_g >= 0) begin
        a_op[last_g] = rand_a();
        b_op[last_g] = rand_b();
      end
    end
    vld = '0;
    for (int i = 0; i < 4; i++) begin
      tick();
      for (int k = 0; k < N; k++) pulses[k] += int'(s_rv[k]);
    end
    for (int k = 0; k < N; k++) chk($sformatf("rr_pulses%0d", k), pulses[k], 2);

    // Fairness after skipping: move the pointer to 2, then only 1 and 3 request
    vld      = '0;
    vld[1]   = 1'b1;
    tick();
    chk("skip_setup_grant", last_g, 1);
    vld = 4'b1010;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("skip_grant%0d", i), last_g, (i % 2 == 0) ? 3 : 1);
      chk($sformatf("skip_idle_ready%0d", i), s_ready[0] | s_ready[2], 0);
    end
    vld = '0;
    repeat (4) tick();

    // Enable dropped after two grants: in-flight results still land, busy then falls
    vld = '1;
    en  = 1'b1;
    tick();
    tick();
    en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("en_off_ready%0d", i), s_ready, 0);
      if (i == 2) chk("en_off_busy_last_result", s_busy, 1);
      if (i == 3) chk("en_off_busy_fallen", s_busy, 0);
    end
    vld = '0;
    en  = 1'b1;

    // Reset one cycle after a grant: the operation vanishes and priority returns to requester 0
    vld    = '0;
    vld[2] = 1'b1;
    a_op[2] = 12345;
    b_op[2] = -678;
    tick();
    chk("midrst_grant", last_g, 2);
    vld = '1;
    do_reset(4);
    tick();
    chk("midrst_first_grant", last_g, 0);
    chk("midrst_no_pulse", s_rv, 0);
    vld = '0;
    repeat (4) tick();

    // Randomized traffic with requesters that hold until served
    for (int c = 0; c < 400; c++) begin
      en = ($urandom_range(0, 9) != 0);
      for (int k = 0; k < N; k++) begin
        if (!vld[k] && $urandom_range(0, 2) == 0) begin
          vld[k]  = 1'b1;
          a_op[k] = rand_a();
          b_op[k] = rand_b();
        end
      end
      tick();
      if (last_g >= 0) vld[last_g] = 1'b0;
    end
    vld = '0;
    en  = 1'b1;
    repeat (5) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
